// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_pkg / cdb_arbiter
//
// Producer end of the common data bus. Each functional unit deposits completed
// results (RS tag + 32-bit value) into its own small FIFO. A round-robin
// arbiter picks one non-empty FIFO per cycle. The winner's head entry is
// registered onto cdb_out. Idle cycles broadcast tag INVALID.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   flush      in   synchronous squash of all buffered results
//   src_valid  in   [NUM_SRC]            source i presents a result
//   src_ready  out  [NUM_SRC]            source i FIFO not full (registered state only)
//   src_tag    in   [NUM_SRC] RS tag     tag of the producing RS
//   src_data   in   [NUM_SRC] x 32       result value
//   cdb_out    out  cdb_t                registered broadcast {tag, data}
//   cdb_src    out  [clog2(NUM_SRC)]     index of the source that won the broadcast
// -----------------------------------------------------------------------------
package cdb_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef logic [TAG_W-1:0] RS_tag_type;

  localparam RS_tag_type INVALID = 4'd0;
  localparam RS_tag_type ALU1    = 4'd1;
  localparam RS_tag_type MUL1    = 4'd3;
  localparam RS_tag_type LOAD1   = 4'd5;
  localparam RS_tag_type LOAD2   = 4'd6;

  typedef struct packed {
    RS_tag_type        tag;
    logic [DATA_W-1:0] data;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                flush,
  input  logic [NUM_SRC-1:0]                  src_valid,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  RS_tag_type [NUM_SRC-1:0]            src_tag,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]      src_data,
  output cdb_t                                cdb_out,
  output logic [$clog2(NUM_SRC)-1:0]          cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(NUM_SRC);

  // Per-source FIFO state
  logic [PW-1:0]     r_wptr [NUM_SRC];
  logic [PW-1:0]     r_rptr [NUM_SRC];
  logic [CW-1:0]     r_cnt  [NUM_SRC];
  cdb_t              r_mem  [NUM_SRC][DEPTH];

  // Broadcast / arbitration state
  cdb_t              r_cdb;
  logic [SW-1:0]     r_cdb_src;
  logic [SW-1:0]     r_rr_ptr;

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nonempty;
  logic               w_any;
  logic [SW-1:0]      w_win;
  logic [SW-1:0]      w_cand;
  cdb_t               w_head;

  // Increment modulo NUM_SRC (NUM_SRC need not be a power of two).
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
    if (int'(v) == NUM_SRC - 1) return '0;
    else                        return v + SW'(1);
  endfunction

  // Ready comes only from registered counts, so pop/flush never reach it
  // combinationally. An INVALID-tag push handshakes but is not stored.
  always_comb begin
    src_ready  = '0;
    w_push     = '0;
    w_nonempty = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i]  = (r_cnt[i] != CW'(DEPTH));
      w_nonempty[i] = (r_cnt[i] != '0);
      w_push[i]     = src_valid[i] && src_ready[i] &&
                      (src_tag[i] != INVALID) && !flush;
    end
  end

  // Round-robin search starting at r_rr_ptr, first non-empty FIFO wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_rr_ptr;
    w_cand = r_rr_ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_any && w_nonempty[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pop[i] = w_any && !flush && (w_win == SW'(i));
    end
  end

  assign w_head = r_mem[w_win][r_rptr[w_win]];

  // Stage 1: buffer accepted results
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  // Storage is not reset; w_push already excludes flush and INVALID tags.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= '{tag: src_tag[i], data: src_data[i]};
    end
  end

  // Stage 2: arbitrate and register the broadcast
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cdb.tag  <= INVALID;
      r_cdb.data <= '0;
      r_cdb_src  <= '0;
      r_rr_ptr   <= '0;
    end else if (flush) begin
      r_cdb.tag  <= INVALID;
    end else if (w_any) begin
      r_cdb      <= w_head;
      r_cdb_src  <= w_win;
      r_rr_ptr   <= wrap_inc(w_win);
    end else begin
      // Idle: data and source index keep their last values.
      r_cdb.tag  <= INVALID;
    end
  end

  assign cdb_out = r_cdb;
  assign cdb_src = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NS = 4;

  logic                   CLK = 1'b0;
  logic                   RST_N = 1'b1;
  logic                   flush;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  RS_tag_type [NS-1:0]    src_tag;
  logic [NS-1:0][31:0]    src_data;
  cdb_t                   cdb_out;
  logic [1:0]             cdb_src;

  cdb_arbiter #(.NUM_SRC(NS), .DEPTH(2)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .cdb_out   (cdb_out),
    .cdb_src   (cdb_src)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Scoreboard: per-source expected results in acceptance order, plus an
  // optional expected winner sequence.
  cdb_t       exp_q [NS][$];
  logic [1:0] exp_src_q [$];
  cdb_t       mon_e;
  int         bc  [NS];
  int         acc [NS];
  bit         bp_mode = 1'b0;
  int         last1   = -1;
  int         seq [NS];
  bit         a_ok [NS];
  int         guard;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each broadcast, then record this cycle's accepts.
  always @(negedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NS; i++) exp_q[i].delete();
      exp_src_q.delete();
    end else begin
      if (cdb_out.tag != INVALID) begin
        bc[cdb_src]++;
        if (exp_q[cdb_src].size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_bcast: got tag 0x%0h data 0x%0h from src %0d, required no broadcast",
                   cdb_out.tag, cdb_out.data, cdb_src);
        end else begin
          mon_e = exp_q[cdb_src].pop_front();
          check("bcast_tag",  64'(cdb_out.tag),  64'(mon_e.tag));
          check("bcast_data", 64'(cdb_out.data), 64'(mon_e.data));
        end
        if (exp_src_q.size() > 0) check("rr_order", 64'(cdb_src), 64'(exp_src_q.pop_front()));
        if (bp_mode && cdb_src == 2'd1) begin
          if (last1 >= 0) check("bp_src1_gap_ge4", 64'((cyc - last1) >= 4), 64'd1);
          last1 = cyc;
        end
      end
      if (flush) begin
        for (int i = 0; i < NS; i++) exp_q[i].delete();
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (src_valid[i] && src_ready[i]) begin
            acc[i]++;
            if (src_tag[i] != INVALID) exp_q[i].push_back('{tag: src_tag[i], data: src_data[i]});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    src_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic set_src(input int i, input RS_tag_type t, input logic [31:0] d);
    src_valid[i] = 1'b1;
    src_tag[i]   = t;
    src_data[i]  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    src_valid = '0;
    flush     = 1'b0;
    src_tag   = '0;
    src_data  = '0;
    for (int i = 0; i < NS; i++) begin bc[i] = 0; acc[i] = 0; seq[i] = 0; end

    // Reset state
    #1 RST_N = 1'b0;
    #2;
    check("rst_ready", 64'(src_ready), 64'h0f);
    check("rst_tag",   64'(cdb_out.tag), 64'(INVALID));
    check("rst_data",  64'(cdb_out.data), 64'd0);
    check("rst_src",   64'(cdb_src), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Round-robin fairness: 2 results per source, rr_ptr starts at 0
    for (int k = 0; k < 8; k++) exp_src_q.push_back(2'(k % 4));
    for (int i = 0; i < NS; i++) set_src(i, RS_tag_type'(i + 1), 32'hA000_0000 + 32'(i));
    tick();
    for (int i = 0; i < NS; i++) set_src(i, RS_tag_type'(i + 5), 32'hB000_0000 + 32'(i));
    tick();
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("rr_slot_src",  64'(cdb_src), 64'(k % 4));
      check("rr_slot_data", 64'(cdb_out.data),
            (k < 4) ? 64'(32'hA000_0000 + 32'(k)) : 64'(32'hB000_0000 + 32'(k - 4)));
    end
    @(negedge CLK);
    check("rr_after_idle", 64'(cdb_out.tag), 64'(INVALID));

    // Single-source latency: push in cycle L, visible only in L+2
    tick();
    set_src(2, LOAD1, 32'hDEADBEEF);
    tick();
    idle_inputs();
    @(negedge CLK);
    check("lat_k1_tag", 64'(cdb_out.tag), 64'(INVALID));
    @(negedge CLK);
    check("lat_k2_tag",  64'(cdb_out.tag), 64'(LOAD1));
    check("lat_k2_data", 64'(cdb_out.data), 64'hDEADBEEF);
    check("lat_k2_src",  64'(cdb_src), 64'd2);
    @(negedge CLK);
    check("lat_k3_tag", 64'(cdb_out.tag), 64'(INVALID));

    // Flush: 5 buffered + a source-0 push in the flush cycle; rr_ptr is 3 here
    tick();
    for (int i = 0; i < NS; i++) set_src(i, RS_tag_type'(i + 1), 32'hF000_0000 + 32'(i));
    tick();
    idle_inputs();
    set_src(1, RS_tag_type'(9),  32'hF100_0001);
    set_src(2, RS_tag_type'(10), 32'hF100_0002);
    tick();
    idle_inputs();
    set_src(0, RS_tag_type'(11), 32'hFF00_0000);
    flush = 1'b1;
    @(negedge CLK);
    check("flush_cycle_ready", 64'(src_ready), 64'h09);
    tick();
    idle_inputs();
    @(negedge CLK);
    check("flush_next_tag",   64'(cdb_out.tag), 64'(INVALID));
    check("flush_next_ready", 64'(src_ready), 64'h0f);
    repeat (6) begin
      @(negedge CLK);
      check("flush_quiet_tag", 64'(cdb_out.tag), 64'(INVALID));
    end

    // INVALID-tag push then 5 valid pushes from source 3, pointers wrap
    bc[3] = 0;
    acc[3] = 0;
    tick();
    set_src(3, INVALID, 32'h3000_0000);
    tick();
    for (int j = 0; j < 5; j++) begin
      set_src(3, RS_tag_type'(6 + j), 32'h3000_0001 + 32'(j));
      @(negedge CLK);
      check("wrap_ready3", 64'(src_ready[3]), 64'd1);
      if (j == 1) check("wrap_invalid_not_stored", 64'(cdb_out.tag), 64'(INVALID));
      if (j >= 2) check("wrap_tag", 64'(cdb_out.tag), 64'(6 + j - 2));
      tick();
    end
    idle_inputs();
    @(negedge CLK);
    check("wrap_tag", 64'(cdb_out.tag), 64'd9);
    @(negedge CLK);
    check("wrap_tag", 64'(cdb_out.tag), 64'd10);
    check("wrap_data", 64'(cdb_out.data), 64'h3000_0005);
    @(negedge CLK);
    check("wrap_end_tag", 64'(cdb_out.tag), 64'(INVALID));
    check("wrap_bcast_count", 64'(bc[3]), 64'd5);
    check("wrap_accept_count", 64'(acc[3]), 64'd6);

    // Back-pressure: all sources push continuously until source 1 has 100 accepts
    for (int i = 0; i < NS; i++) begin bc[i] = 0; acc[i] = 0; seq[i] = 0; end
    last1 = -1;
    guard = 0;
    tick();
    while (seq[1] < 100 && guard < 2000) begin
      for (int i = 0; i < NS; i++)
        set_src(i, RS_tag_type'(1 + (seq[i] % 15)), {4'(i), 28'(seq[i])});
      @(negedge CLK);
      for (int i = 0; i < NS; i++) a_ok[i] = src_ready[i];
      if (guard < 3) check("bp_ready1_early", 64'(src_ready[1]), 64'(guard < 2));
      if (guard >= 4) bp_mode = 1'b1;
      tick();
      for (int i = 0; i < NS; i++) if (a_ok[i]) seq[i]++;
      guard++;
    end
    bp_mode = 1'b0;
    idle_inputs();
    check("bp_no_timeout", 64'(guard < 2000), 64'd1);
    repeat (20) tick();
    check("bp_src1_bcast_count", 64'(bc[1]), 64'd100);
    check("bp_src1_accept_count", 64'(acc[1]), 64'd100);
    for (int i = 0; i < NS; i++) check("bp_drained", 64'(exp_q[i].size()), 64'd0);

    // Asynchronous reset mid-stream
    set_src(0, ALU1,  32'h0000_0011);
    set_src(1, MUL1,  32'h0000_0022);
    set_src(2, LOAD2, 32'h0000_0033);
    tick();
    idle_inputs();
    set_src(3, RS_tag_type'(12), 32'h0000_0044);
    tick();
    idle_inputs();
    #2;
    check("prereset_tag_valid", 64'(cdb_out.tag != INVALID), 64'd1);
    RST_N = 1'b0;
    #1;
    check("async_rst_tag",   64'(cdb_out.tag), 64'(INVALID));
    check("async_rst_ready", 64'(src_ready), 64'h0f);
    check("async_rst_src",   64'(cdb_src), 64'd0);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("post_rst_tag", 64'(cdb_out.tag), 64'(INVALID));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
